// File: rtl/nco_sweep_pkg.sv
// nco_sweep_pkg: shared state encoding and default widths for the NCO sweep controller
package nco_sweep_pkg;
  localparam int APR_DEF  = 32;
  localparam int CNTW_DEF = 16;
  typedef enum logic [1:0] {IDLE, SWEEP, HOLD} state_e;
endpackage

// File: rtl/nco_sweep_dwell_cnt.sv
// nco_sweep_dwell_cnt: loadable down-counter timing how long each frequency is held
import nco_sweep_pkg::*;
module nco_sweep_dwell_cnt #(
  parameter int CNTW = CNTW_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load_i,
  input  logic            dec_i,
  input  logic [CNTW-1:0] load_val_i,
  output logic            zero_o
);
  logic [CNTW-1:0] cnt_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else if (load_i) cnt_q <= load_val_i;
    else if (dec_i) cnt_q <= cnt_q - CNTW'(1);
  end
  assign zero_o = cnt_q == '0;
endmodule

// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl: steps an NCO phase increment from f_start by f_step, holding each
// frequency dwell+1 cycles, in single-shot or continuous mode
import nco_sweep_pkg::*;
module nco_sweep_ctrl #(
  parameter int APR  = APR_DEF,
  parameter int CNTW = CNTW_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            abort,
  input  logic            cont,
  input  logic [APR-1:0]  f_start,
  input  logic [APR-1:0]  f_step,
  input  logic [CNTW-1:0] n_steps,
  input  logic [CNTW-1:0] dwell,
  output logic [APR-1:0]  phi_inc_o,
  output logic            nco_clken_o,
  output logic            busy,
  output logic            done,
  output logic [CNTW-1:0] step_idx
);
  state_e          state_q, state_d;
  logic [APR-1:0]  phi_q, phi_d, fs_q, fs_d, st_q, st_d;
  logic [CNTW-1:0] idx_q, idx_d, n_q, n_d, dw_q, dw_d, cnt_val;
  logic            cont_q, cont_d, done_q, done_d, cnt_load, cnt_dec, cnt_zero;

  nco_sweep_dwell_cnt #(.CNTW(CNTW)) u_dwell (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (cnt_load),
    .dec_i      (cnt_dec),
    .load_val_i (cnt_val),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    phi_d    = phi_q;
    idx_d    = idx_q;
    fs_d     = fs_q;
    st_d     = st_q;
    n_d      = n_q;
    dw_d     = dw_q;
    cont_d   = cont_q;
    done_d   = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = dw_q;
    if (abort) begin
      state_d  = IDLE;
      phi_d    = '0;
      idx_d    = '0;
      cnt_load = 1'b1;
      cnt_val  = '0;
    end else if (start && state_q != SWEEP) begin
      state_d  = SWEEP;
      fs_d     = f_start;
      st_d     = f_step;
      n_d      = n_steps;
      dw_d     = dwell;
      cont_d   = cont;
      phi_d    = f_start;
      idx_d    = '0;
      cnt_load = 1'b1;
      cnt_val  = dwell;
    end else if (state_q == SWEEP) begin
      cnt_dec = !cnt_zero;
      if (cnt_zero) begin
        cnt_load = 1'b1;
        if (idx_q < n_q) begin
          phi_d = phi_q + st_q;
          idx_d = idx_q + CNTW'(1);
        end else if (cont_q) begin
          phi_d = fs_q;
          idx_d = '0;
        end else begin
          state_d = HOLD;
          done_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      phi_q   <= '0;
      idx_q   <= '0;
      fs_q    <= '0;
      st_q    <= '0;
      n_q     <= '0;
      dw_q    <= '0;
      cont_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phi_q   <= phi_d;
      idx_q   <= idx_d;
      fs_q    <= fs_d;
      st_q    <= st_d;
      n_q     <= n_d;
      dw_q    <= dw_d;
      cont_q  <= cont_d;
      done_q  <= done_d;
    end
  end

  assign phi_inc_o   = phi_q;
  assign step_idx    = idx_q;
  assign done        = done_q;
  assign busy        = state_q == SWEEP;
  assign nco_clken_o = state_q != IDLE;
endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// tb_nco_sweep_ctrl: directed sweeps with hand-computed expected phase increments
module tb_nco_sweep_ctrl;
  logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0, cont = 1'b0;
  logic [31:0] f_start = '0, f_step = '0, phi_inc_o;
  logic [15:0] n_steps = '0, dwell = '0, step_idx;
  logic        nco_clken_o, busy, done;
  int          total = 0, bad = 0;

  nco_sweep_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .abort       (abort),
    .cont        (cont),
    .f_start     (f_start),
    .f_step      (f_step),
    .n_steps     (n_steps),
    .dwell       (dwell),
    .phi_inc_o   (phi_inc_o),
    .nco_clken_o (nco_clken_o),
    .busy        (busy),
    .done        (done),
    .step_idx    (step_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [31:0] fs, input logic [31:0] st, input logic [15:0] n,
                          input logic [15:0] d, input logic c);
    f_start = fs;
    f_step  = st;
    n_steps = n;
    dwell   = d;
    cont    = c;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_phi"}, phi_inc_o, 0);
    chk({tag, "_clken"}, nco_clken_o, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_idx"}, step_idx, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_idle("rst");
    chk("rst_done", done, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk_idle("idle");
    do_start(32'h1000, 32'h100, 3, 2, 1'b0);
    for (int i = 0; i < 12; i++) begin
      chk("t1_phi", phi_inc_o, 32'h1000 + (i / 3) * 32'h100);
      chk("t1_idx", step_idx, i / 3);
      chk("t1_busy", busy, 1);
      chk("t1_clken", nco_clken_o, 1);
      chk("t1_done", done, 0);
      @(negedge clk);
    end
    chk("t1_hold_done", done, 1);
    chk("t1_hold_busy", busy, 0);
    chk("t1_hold_clken", nco_clken_o, 1);
    chk("t1_hold_phi", phi_inc_o, 32'h1300);
    @(negedge clk);
    chk("t1_done_once", done, 0);
    chk("t1_hold_phi2", phi_inc_o, 32'h1300);
    do_start(32'h1000, 32'h100, 3, 2, 1'b1);
    for (int i = 0; i < 24; i++) begin
      chk("t2_phi", phi_inc_o, 32'h1000 + ((i % 12) / 3) * 32'h100);
      chk("t2_done", done, 0);
      chk("t2_busy", busy, 1);
      if (i == 5) begin
        f_start = 32'h5555;
        f_step  = 32'h7;
        start   = 1'b1;
      end
      if (i == 6) start = 1'b0;
      @(negedge clk);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk_idle("abort_mid");
    do_start(32'hFFFFFF00, 32'h200, 1, 0, 1'b0);
    chk("t3_phi0", phi_inc_o, 32'hFFFFFF00);
    @(negedge clk);
    chk("t3_wrap", phi_inc_o, 32'h00000100);
    @(negedge clk);
    chk("t3_done", done, 1);
    do_start(32'h1000, 32'hFFFFFF00, 2, 0, 1'b0);
    chk("t4_phi0", phi_inc_o, 32'h1000);
    @(negedge clk);
    chk("t4_phi1", phi_inc_o, 32'h0F00);
    @(negedge clk);
    chk("t4_phi2", phi_inc_o, 32'h0E00);
    @(negedge clk);
    chk("t4_done", done, 1);
    chk("t4_hold_phi", phi_inc_o, 32'h0E00);
    do_start(32'h2222, 32'h10, 0, 1, 1'b0);
    chk("t5_phi0", phi_inc_o, 32'h2222);
    chk("t5_done0", done, 0);
    @(negedge clk);
    chk("t5_phi1", phi_inc_o, 32'h2222);
    chk("t5_done1", done, 0);
    @(negedge clk);
    chk("t5_done", done, 1);
    chk("t5_hold_phi", phi_inc_o, 32'h2222);
    abort = 1'b1;
    do_start(32'h3000, 32'h100, 3, 2, 1'b0);
    abort = 1'b0;
    chk_idle("abort_start");
    chk("abort_start_done", done, 0);
    do_start(32'h1000, 32'h100, 3, 2, 1'b0);
    repeat (4) @(negedge clk);
    chk("t6_pre_phi", phi_inc_o, 32'h1100);
    #2 reset_n = 1'b0;
    #1;
    chk_idle("async_rst");
    chk("async_rst_done", done, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    do_start(32'h1000, 32'h100, 3, 2, 1'b0);
    for (int i = 0; i < 6; i++) begin
      chk("t6_phi", phi_inc_o, 32'h1000 + (i / 3) * 32'h100);
      chk("t6_busy", busy, 1);
      @(negedge clk);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/nco_sweep_ctrl.md
NCO_SWEEP_CTRL -- requirements
Module: nco_sweep_ctrl

Interface
REQ-001 The block SHALL have parameter APR, default 32: width of the phase increment word; it matches the NCO phi_inc_i width.
REQ-002 The block SHALL have parameter CNTW, default 16: width of the step and dwell counters.
REQ-003 Port clk, input, 1: single clock for the block; all state SHALL update on its rising edge.
REQ-004 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 Port start, input, 1: single-cycle request to begin a sweep.
REQ-006 Port abort, input, 1: stops any sweep and returns the block to idle.
REQ-007 Port cont, input, 1: 0 = single sweep, 1 = continuous (repeating) sweep.
REQ-008 Port f_start, input, APR: starting phase increment.
REQ-009 Port f_step, input, APR: two's-complement increment added per step.
REQ-010 Port n_steps, input, CNTW: number of steps after the first frequency.
REQ-011 Port dwell, input, CNTW: each frequency is held for dwell+1 cycles.
REQ-012 Port phi_inc_o, output, APR: phase increment to the NCO phi_inc_i.
REQ-013 Port nco_clken_o, output, 1: clock enable to the NCO clken.
REQ-014 Port busy, output, 1: high while the state is SWEEP.
REQ-015 Port done, output, 1: single-cycle pulse when a single sweep completes.
REQ-016 Port step_idx, output, CNTW: index of the current step.

Function
REQ-017 The state machine SHALL have exactly three states: IDLE, SWEEP and HOLD.
REQ-018 In IDLE, phi_inc_o and nco_clken_o SHALL be 0.
REQ-019 In SWEEP and HOLD, nco_clken_o SHALL be 1.
REQ-020 On start in IDLE or HOLD, the block SHALL latch f_start, f_step, n_steps, dwell and cont, then enter SWEEP.
REQ-021 One cycle after start is sampled, the block SHALL drive phi_inc_o = f_start, step_idx = 0, busy = 1 and nco_clken_o = 1.
REQ-022 Changes on the config inputs during SWEEP SHALL have no effect until the next accepted start.
REQ-023 In SWEEP, the dwell counter SHALL load the latched dwell value and decrement each cycle.
REQ-024 When the dwell counter reaches 0 and step_idx < n_steps, phi_inc_o SHALL take phi_inc_o + f_step modulo 2^APR on the next cycle, step_idx SHALL increment, and the dwell counter SHALL reload.
REQ-025 When the dwell counter reaches 0 and step_idx == n_steps with cont = 0, the block SHALL enter HOLD and pulse done for one cycle; phi_inc_o SHALL keep the final value.
REQ-026 When the dwell counter reaches 0 and step_idx == n_steps with cont = 1, the block SHALL reload phi_inc_o = f_start and step_idx = 0, stay in SWEEP, and not pulse done.
REQ-027 With n_steps = 0, the block SHALL output only f_start, for dwell+1 cycles, before HOLD or the restart.
REQ-028 With dwell = 0, the frequency SHALL change every cycle.
REQ-029 The block SHALL ignore start while in SWEEP.
REQ-030 In HOLD, start SHALL restart the sweep from the newly latched configuration.
REQ-031 abort in any state SHALL return the block to IDLE on the next cycle and clear phi_inc_o, step_idx and busy.
REQ-032 When abort and start are high in the same cycle, abort SHALL win.
REQ-033 An addition that overflows 2^APR SHALL wrap silently.

Reset
REQ-034 While reset_n is low, the block SHALL be in IDLE with phi_inc_o = 0, nco_clken_o = 0, busy = 0, done = 0, step_idx = 0, the dwell counter = 0 and all latched config = 0.
REQ-035 Reset asserted mid-sweep SHALL take effect immediately, without waiting for a clock edge.

Structure
REQ-036 Package nco_sweep_pkg SHALL hold the state enum (IDLE, SWEEP, HOLD) and the default APR/CNTW constants.
REQ-037 Sub-module nco_sweep_dwell_cnt SHALL implement the loadable CNTW-bit down-counter with a zero flag; everything else SHALL be flat.

Verification
REQ-038 f_start=0x1000, f_step=0x100, n_steps=3, dwell=2, cont=0, start -> phi_inc_o = 0x1000, 0x1100, 0x1200, 0x1300, 3 cycles each; then done pulses once, the block enters HOLD and phi_inc_o stays at 0x1300.
REQ-039 The same config with cont=1 -> the 0x1000..0x1300 sequence repeats with no gap, and done is never asserted.
REQ-040 f_start=0xFFFFFF00, f_step=0x200, n_steps=1, dwell=0 -> phi_inc_o = 0xFFFFFF00 then 0x00000100 (wrap).
REQ-041 f_step=0xFFFFFF00 (-256), f_start=0x1000, n_steps=2 -> phi_inc_o = 0x1000, 0x0F00, 0x0E00.
REQ-042 abort asserted in the same cycle as start, and again mid-sweep -> the next cycle shows IDLE with phi_inc_o = 0, nco_clken_o = 0 and busy = 0.
REQ-043 reset_n pulsed low mid-sweep -> all outputs go to 0 asynchronously, and a start after reset_n returns high runs a normal sweep.
